// File: rtl/cache_assoc.sv
// Set-associative write-back, write-allocate cache with true-LRU replacement.
// One access at a time; misses go through a single blocking backing-memory port.
module cache_assoc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int WAYS   = 4,
  parameter int SETS   = 2,
  localparam int LRU_W = $clog2(WAYS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         wren,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            data,
  output logic [DATA_W-1:0]            q,
  output logic                         ready,
  output logic                         hit,
  output logic                         mem_req,
  output logic                         mem_wren,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_data,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_q,
  output logic [2:0]                   state,
  output logic [WAYS*SETS-1:0]         dirty,
  output logic [WAYS*SETS*LRU_W-1:0]   lru
);

  localparam int IDX_W  = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int TAG_W  = ADDR_W - IDX_W;
  localparam int LINES  = WAYS * SETS;
  localparam int LINE_W = $clog2(LINES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                hit_q, hit_d;
  logic [LRU_W-1:0]    victim_q, victim_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic [TAG_W-1:0]    tag_d [LINES];
  logic [LRU_W-1:0]    lru_q [LINES];
  logic [LRU_W-1:0]    lru_d [LINES];
  logic [DATA_W-1:0]   line_data_q [LINES];

  logic                line_we;
  logic [LINE_W-1:0]   line_wsel;
  logic [DATA_W-1:0]   line_wdata;

  logic [ADDR_W-1:0]   set_idx;
  logic [TAG_W-1:0]    tag_in;
  logic [LINE_W-1:0]   line_base;
  logic [LINE_W-1:0]   vic_line;
  logic                hit_any, found_inv;
  logic [LRU_W-1:0]    hit_way, inv_way, lru_way, victim_way;
  logic [LRU_W-1:0]    acc_way, acc_old;
  logic                touch;

  assign set_idx   = addr_q & ADDR_W'(SETS - 1);
  assign tag_in    = TAG_W'(addr_q >> IDX_W);
  assign line_base = LINE_W'(set_idx) << LRU_W;
  assign vic_line  = line_base + LINE_W'(victim_q);

  // Tag match and victim choice: first invalid way, else the oldest way.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[line_base + LINE_W'(w)] && tag_q[line_base + LINE_W'(w)] == tag_in && !hit_any) begin
        hit_any = 1'b1;
        hit_way = LRU_W'(w);
      end
      if (!valid_q[line_base + LINE_W'(w)] && !found_inv) begin
        found_inv = 1'b1;
        inv_way   = LRU_W'(w);
      end
      if (lru_q[line_base + LINE_W'(w)] == LRU_W'(WAYS - 1)) lru_way = LRU_W'(w);
    end
    victim_way = found_inv ? inv_way : lru_way;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wren_d     = wren_q;
    wdata_d    = wdata_q;
    q_d        = q_q;
    hit_d      = hit_q;
    victim_d   = victim_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    lru_d      = lru_q;
    line_we    = 1'b0;
    line_wsel  = '0;
    line_wdata = wdata_q;
    acc_way    = '0;
    touch      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = address;
          wren_d  = wren;
          wdata_d = data;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          hit_d   = 1'b1;
          acc_way = hit_way;
          touch   = 1'b1;
          if (wren_q) begin
            line_we   = 1'b1;
            line_wsel = line_base + LINE_W'(hit_way);
            dirty_d[line_base + LINE_W'(hit_way)] = 1'b1;
            q_d       = wdata_q;
          end else begin
            q_d = line_data_q[line_base + LINE_W'(hit_way)];
          end
          state_d = S_RESPOND;
        end else begin
          victim_d = victim_way;
          if (valid_q[line_base + LINE_W'(victim_way)] && dirty_q[line_base + LINE_W'(victim_way)])
            state_d = S_WRITEBACK;
          else
            state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (mem_ack) begin
          line_we           = 1'b1;
          line_wsel         = vic_line;
          line_wdata        = wren_q ? wdata_q : mem_q;
          valid_d[vic_line] = 1'b1;
          dirty_d[vic_line] = wren_q;
          tag_d[vic_line]   = tag_in;
          q_d               = wren_q ? wdata_q : mem_q;
          hit_d             = 1'b0;
          acc_way           = victim_q;
          touch             = 1'b1;
          state_d           = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Accessed way becomes youngest; only ways younger than it age by one.
    acc_old = lru_q[line_base + LINE_W'(acc_way)];
    if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (LRU_W'(w) == acc_way)
          lru_d[line_base + LINE_W'(w)] = '0;
        else if (lru_q[line_base + LINE_W'(w)] < acc_old)
          lru_d[line_base + LINE_W'(w)] = lru_q[line_base + LINE_W'(w)] + LRU_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wren_q   <= 1'b0;
      wdata_q  <= '0;
      q_q      <= '0;
      hit_q    <= 1'b0;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        lru_q[i] <= LRU_W'(i % WAYS);
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wren_q   <= wren_d;
      wdata_q  <= wdata_d;
      q_q      <= q_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      tag_q    <= tag_d;
      lru_q    <= lru_d;
    end
  end

  always_ff @(posedge clock) begin
    if (line_we) line_data_q[line_wsel] <= line_wdata;
  end

  assign state    = state_q;
  assign q        = q_q;
  assign hit      = hit_q;
  assign ready    = (state_q == S_RESPOND);
  assign mem_req  = (state_q == S_WRITEBACK) || (state_q == S_ALLOCATE);
  assign mem_wren = (state_q == S_WRITEBACK);
  assign mem_address = (state_q == S_WRITEBACK) ? ((ADDR_W'(tag_q[vic_line]) << IDX_W) | set_idx) :
                       (state_q == S_ALLOCATE)  ? addr_q : '0;
  assign mem_data = (state_q == S_WRITEBACK) ? line_data_q[vic_line] : '0;
  assign dirty    = dirty_q;

  for (genvar i = 0; i < LINES; i++) begin : g_lru
    assign lru[i*LRU_W +: LRU_W] = lru_q[i];
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc: recency-list cache model plus reference memory,
// directed scenarios and a random access run.
module tb_cache_assoc;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int WAYS   = 4;
  localparam int SETS   = 2;

  logic        clock = 1'b0;
  logic        reset, req, wren;
  logic [4:0]  address;
  logic [7:0]  data, q;
  logic        ready, hit, mem_req, mem_wren;
  logic [4:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic [7:0]  mem_q;
  logic [2:0]  state;
  logic [7:0]  dirty;
  logic [15:0] lru;

  cache_assoc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAYS(WAYS), .SETS(SETS)) dut (
    .clock(clock), .reset(reset), .req(req), .wren(wren), .address(address), .data(data),
    .q(q), .ready(ready), .hit(hit), .mem_req(mem_req), .mem_wren(mem_wren),
    .mem_address(mem_address), .mem_data(mem_data), .mem_ack(mem_ack), .mem_q(mem_q),
    .state(state), .dirty(dirty), .lru(lru));

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] q; bit hit; logic [7:0] dirty; logic [15:0] lru; int t_req; } exp_t;
  typedef struct { logic [4:0] a; bit w; logic [7:0] d; } mtx_t;

  logic [7:0] mem [32];
  bit         m_valid [SETS][WAYS];
  bit         m_dirty [SETS][WAYS];
  int         m_tag   [SETS][WAYS];
  logic [7:0] m_data  [SETS][WAYS];
  int         m_rec   [SETS][$];   // ways ordered most- to least-recently used
  exp_t       exp_q [$];
  mtx_t       mtx_q [$];

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rec[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_rec[s].push_back(w);
      end
    end
    exp_q.delete();
    mtx_q.delete();
  endfunction

  function automatic exp_t model_access(bit w, logic [4:0] a, logic [7:0] d);
    int s, t, way;
    exp_t e;
    s = int'(a) % SETS;
    t = int'(a) / SETS;
    way = -1;
    for (int i = 0; i < WAYS; i++)
      if (way < 0 && m_valid[s][i] && m_tag[s][i] == t) way = i;
    if (way >= 0) begin
      e.hit = 1;
      if (w) begin m_data[s][way] = d; m_dirty[s][way] = 1; end
    end else begin
      e.hit = 0;
      for (int i = 0; i < WAYS; i++)
        if (way < 0 && !m_valid[s][i]) way = i;
      if (way < 0) way = m_rec[s][m_rec[s].size()-1];
      if (m_valid[s][way] && m_dirty[s][way])
        mtx_q.push_back('{5'(m_tag[s][way]*SETS + s), 1'b1, m_data[s][way]});
      mtx_q.push_back('{a, 1'b0, 8'h00});
      m_valid[s][way] = 1;
      m_tag[s][way]   = t;
      m_dirty[s][way] = w;
      m_data[s][way]  = w ? d : mem[a];
    end
    e.q = m_data[s][way];
    for (int p = 0; p < m_rec[s].size(); p++)
      if (m_rec[s][p] == way) begin m_rec[s].delete(p); break; end
    m_rec[s].push_front(way);
    e.dirty = '0;
    e.lru   = '0;
    for (int s2 = 0; s2 < SETS; s2++)
      for (int p = 0; p < WAYS; p++) begin
        e.dirty[s2*WAYS+p] = m_dirty[s2][p];
        e.lru[(s2*WAYS + m_rec[s2][p])*2 +: 2] = 2'(p);
      end
    e.t_req = 0;
    return e;
  endfunction

  // ---------------- backing memory responder ----------------
  int         ack_delay = 0, mcnt = 0;
  bit         busy = 0;
  logic [4:0] t_a;
  logic       t_w;
  logic [7:0] t_d;
  logic [4:0] last_wb_addr, last_alloc_addr;
  logic [7:0] last_wb_data;

  always @(negedge clock) begin
    mtx_t m;
    if (mem_ack) begin
      mem_ack = 1'b0;
      busy    = 0;
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1; mcnt = 0;
        t_a = mem_address; t_w = mem_wren; t_d = mem_data;
        chk("mem_tx_expected", mtx_q.size() > 0, 1);
        if (mtx_q.size() > 0) begin
          m = mtx_q.pop_front();
          chk("mem_address", mem_address, m.a);
          chk("mem_wren", mem_wren, m.w);
          if (m.w) chk("mem_data", mem_data, m.d);
        end
        if (mem_wren) begin last_wb_addr = mem_address; last_wb_data = mem_data; end
        else last_alloc_addr = mem_address;
      end else begin
        chk("mem_address_stable", mem_address, t_a);
        chk("mem_wren_stable", mem_wren, t_w);
        chk("mem_data_stable", mem_data, t_d);
      end
      if (mcnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_wren) mem[mem_address] = mem_data;
        else mem_q = mem[mem_address];
      end else mcnt++;
    end else busy = 0;
  end

  // ---------------- output compare ----------------
  int         done_cnt = 0, ready_cnt = 0, mreq_cycles = 0;
  logic [7:0] last_q;
  logic       last_hit;

  always @(negedge clock) begin
    exp_t e;
    logic [3:0] seen;
    if (!reset) begin
      if (mem_req) mreq_cycles++;
      if (state == 3'd0 || state == 3'd1 || state == 3'd4) chk("mem_req_quiet", mem_req, 0);
      if (ready) begin
        ready_cnt++;
        last_q = q;
        last_hit = hit;
        chk("ready_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("q", q, e.q);
          chk("hit", hit, e.hit);
          chk("dirty", dirty, e.dirty);
          chk("lru", lru, e.lru);
          if (e.hit) chk("hit_latency", cyc - e.t_req, 2);
        end
        for (int s = 0; s < SETS; s++) begin
          seen = '0;
          for (int w = 0; w < WAYS; w++) seen[lru[(s*WAYS+w)*2 +: 2]] = 1'b1;
          chk("lru_perm", seen, 4'hF);
        end
        done_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (state == 3'd0) return;
    end
    chk("idle_timeout", state, 0);
  endtask

  task automatic wait_done(input int d0);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock); #1;
      if (done_cnt != d0) got = 1;
    end
    chk("ready_timeout", got, 1);
  endtask

  task automatic do_access(input bit w, input logic [4:0] a, input logic [7:0] d,
                           output logic [7:0] oq, output logic ohit, output int omc);
    exp_t e;
    int d0, m0;
    wait_idle();
    e = model_access(w, a, d);
    e.t_req = cyc;
    exp_q.push_back(e);
    d0 = done_cnt; m0 = mreq_cycles;
    req = 1'b1; wren = w; address = a; data = d;
    @(negedge clock);
    req = 1'b0;
    wait_done(d0);
    oq = last_q; ohit = last_hit; omc = mreq_cycles - m0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rq;
    logic       rh;
    int         mc, r0, d0;
    exp_t       e;

    reset = 1'b1; req = 1'b0; wren = 1'b0; address = '0; data = '0;
    mem_ack = 1'b0; mem_q = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i*7 + 3) ^ 8'h40;
    mem[4] = 8'h5A;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset values
    chk("rst_state", state, 0);
    chk("rst_ready", ready, 0);
    chk("rst_hit", hit, 0);
    chk("rst_q", q, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_dirty", dirty, 8'h00);
    chk("rst_lru", lru, 16'hE4E4);

    // read miss then read hit of 0x04
    do_access(0, 5'h04, 8'h00, rq, rh, mc);
    chk("rd04_miss_q", rq, 8'h5A);
    chk("rd04_miss_hit", rh, 0);
    chk("rd04_alloc_addr", last_alloc_addr, 5'h04);
    do_access(0, 5'h04, 8'h00, rq, rh, mc);
    chk("rd04_hit_q", rq, 8'h5A);
    chk("rd04_hit_hit", rh, 1);
    chk("rd04_hit_memreq", mc, 0);

    // write hit, then read back
    do_access(1, 5'h04, 8'hA5, rq, rh, mc);
    chk("wr04_hit", rh, 1);
    chk("wr04_dirty_w0", dirty[0], 1);
    chk("wr04_memreq", mc, 0);
    do_access(0, 5'h04, 8'h00, rq, rh, mc);
    chk("rd04_after_wr", rq, 8'hA5);

    // dirty LRU victim eviction
    apply_reset();
    do_access(1, 5'h00, 8'h11, rq, rh, mc);
    do_access(0, 5'h02, 8'h00, rq, rh, mc);
    do_access(0, 5'h04, 8'h00, rq, rh, mc);
    do_access(0, 5'h06, 8'h00, rq, rh, mc);
    last_wb_addr = 5'h1F; last_wb_data = 8'h00;
    do_access(0, 5'h08, 8'h00, rq, rh, mc);
    chk("evict_wb_addr", last_wb_addr, 5'h00);
    chk("evict_wb_data", last_wb_data, 8'h11);
    chk("evict_alloc_addr", last_alloc_addr, 5'h08);
    chk("evict_hit", rh, 0);
    chk("evict_q", rq, 8'h7B);

    // slow memory, stray req during the wait
    ack_delay = 5;
    wait_idle();
    e = model_access(0, 5'h0A, 8'h00);
    e.t_req = cyc;
    exp_q.push_back(e);
    r0 = ready_cnt; d0 = done_cnt;
    req = 1'b1; wren = 1'b0; address = 5'h0A;
    @(negedge clock); req = 1'b0;
    repeat (2) @(negedge clock);
    chk("stray_in_alloc", state, 3);
    req = 1'b1; wren = 1'b1; address = 5'h10; data = 8'hEE;
    @(negedge clock); req = 1'b0;
    wait_done(d0);
    repeat (10) @(negedge clock);
    chk("stray_ready_pulses", ready_cnt - r0, 1);
    chk("slow_q", last_q, 8'h09);

    // reset while waiting on a writeback
    apply_reset();
    ack_delay = 0;
    do_access(1, 5'h00, 8'h21, rq, rh, mc);
    do_access(1, 5'h02, 8'h22, rq, rh, mc);
    do_access(1, 5'h04, 8'h23, rq, rh, mc);
    do_access(1, 5'h06, 8'h24, rq, rh, mc);
    ack_delay = 20;
    wait_idle();
    e = model_access(0, 5'h08, 8'h00);
    exp_q.push_back(e);
    req = 1'b1; wren = 1'b0; address = 5'h08;
    @(negedge clock); req = 1'b0;
    for (int i = 0; i < 20 && state != 3'd2; i++) @(negedge clock);
    chk("reached_writeback", state, 2);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_state", state, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_dirty", dirty, 8'h00);
    chk("abort_lru", lru, 16'hE4E4);
    chk("abort_ready", ready, 0);
    reset = 1'b0;
    model_reset();
    ack_delay = 0;
    do_access(0, 5'h00, 8'h00, rq, rh, mc);
    chk("post_abort_hit", rh, 0);
    chk("post_abort_q", rq, 8'h11);

    // random traffic
    for (int n = 0; n < 1000; n++) begin
      ack_delay = $urandom_range(0, 3);
      do_access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), rq, rh, mc);
    end

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 5, word address width.
REQ-003 Parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-004 Parameter SETS, default 2, number of sets; power of two, 1..16; IDX_W = log2(SETS), min 0; LRU_W = log2(WAYS).
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  1  processor access request; sampled only in IDLE.
REQ-008 wren  input  1  1 = write, 0 = read; sampled with req.
REQ-009 address  input  ADDR_W  word address: index = address[IDX_W-1:0], tag = remaining upper bits.
REQ-010 data  input  DATA_W  write data; sampled with req.
REQ-011 q  output  DATA_W  read data; valid while ready=1.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 hit  output  1  hit/miss result of the completed access; valid while ready=1; holds until the next completion.
REQ-014 mem_req, mem_wren  output  1 each  backing-memory request and write-enable.
REQ-015 mem_address  output  ADDR_W; mem_data  output  DATA_W  backing-memory address and write data.
REQ-016 mem_ack  input  1; mem_q  input  DATA_W  memory completion pulse; mem_q is valid in the same cycle as mem_ack.
REQ-017 state  output  3  FSM encoding: IDLE=0, LOOKUP=1, WRITEBACK=2, ALLOCATE=3, RESPOND=4.
REQ-018 dirty  output  WAYS*SETS; lru  output  WAYS*SETS*LRU_W  per-line debug flags, line index = set*WAYS + way.

Function
REQ-019 IDLE: when req=1, latch address/wren/data and go to LOOKUP; when req=0, stay in IDLE. req is ignored in every other state.
REQ-020 LOOKUP: hit = any way in the indexed set with valid=1 and matching tag.
REQ-021 Hit, read: q <= line data. Hit, write: line data <= data, dirty <= 1, q <= data, no memory traffic. Next state RESPOND.
REQ-022 Miss victim: lowest-numbered invalid way; if none, the way with lru = WAYS-1.
REQ-023 Miss with dirty victim: go to WRITEBACK. Miss with clean or invalid victim: go to ALLOCATE.
REQ-024 WRITEBACK: mem_req=1, mem_wren=1, mem_address={victim tag, index}, mem_data=victim data; all held stable until mem_ack; on mem_ack go to ALLOCATE.
REQ-025 ALLOCATE: mem_req=1, mem_wren=0, mem_address=latched address, held until mem_ack.
REQ-026 ALLOCATE on mem_ack, read access: line <= mem_q, valid=1, dirty=0, q <= mem_q.
REQ-027 ALLOCATE on mem_ack, write access: line <= data, valid=1, dirty=1, q <= data.
REQ-028 ALLOCATE on mem_ack: tag updated; go to RESPOND.
REQ-029 RESPOND: ready=1 for exactly this cycle; next state IDLE. Hit latency: ready is high 2 cycles after the req-sampling edge.
REQ-030 mem_req is 0 in IDLE, LOOKUP and RESPOND; mem_req drops in the cycle after mem_ack; mem_ack outside WRITEBACK/ALLOCATE is ignored.
REQ-031 LRU update on every completed access (hit or fill) for the accessed set: accessed way <= 0; ways with lru < old value of the accessed way increment; others unchanged.
REQ-032 LRU values within each set always form a permutation of 0..WAYS-1.
REQ-033 Back-to-back: a req held high through RESPOND is accepted in the following IDLE cycle, not earlier.

Reset
REQ-034 On reset=1 at a clock edge: state=IDLE; all valid and dirty bits = 0; lru of way w = w in every set.
REQ-035 On reset: q=0, ready=0, hit=0, mem_req=0, mem_wren=0, mem_address=0, mem_data=0.
REQ-036 Reset mid-operation, including while waiting for mem_ack, aborts the access: no completion pulse, mem_req low from the next cycle, the pending mem_ack is ignored.
REQ-037 Line data arrays need not be reset.

Verification (WAYS=4, SETS=2, ADDR_W=5, DATA_W=8)
REQ-038 After reset, read 0x04 with mem[0x04]=0x5A -> ALLOCATE mem_address=0x04, then ready with q=0x5A, hit=0; repeat read 0x04 -> hit=1, q=0x5A, ready 2 cycles after req, mem_req stays 0.
REQ-039 Write 0xA5 to 0x04 after REQ-038 -> hit=1, dirty bit of set0 way0 = 1, mem_req stays 0; read 0x04 -> q=0xA5.
REQ-040 After reset: write 0x11 to 0x00, then read 0x02, 0x04, 0x06, then read 0x08 -> WRITEBACK mem_address=0x00 mem_data=0x11, then ALLOCATE 0x08, victim way0, hit=0.
REQ-041 mem_ack delayed 5 cycles, req pulsed during wait -> mem_req/mem_address stable throughout; extra req ignored; exactly one ready pulse.
REQ-042 reset asserted during WRITEBACK with mem_ack low -> next cycle state=0, mem_req=0, dirty=0, lru reset values; subsequent read 0x00 misses.
REQ-043 Random 1000-access sequence against a reference memory model -> every q matches the model, every set's lru remains a permutation.
